// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, shift-unit FSM states and
// shift-kind encodings used by the execute-stage shifters.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  localparam logic SH_LOGICAL = 1'b0;
  localparam logic SH_ARITH   = 1'b1;

endpackage

// File: rtl/serial_shift_right_if.sv
// Request/response handshake bundle for the serial right shifter.
// The master issues shift requests and consumes results.
interface serial_shift_right_if
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int SHW  = riscv_pkg::SHW
);

  logic            in_valid;
  logic            in_ready;
  logic            in_arith;
  logic [XLEN-1:0] in_operand;
  logic [SHW-1:0]  in_shamt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid,
    output in_arith,
    output in_operand,
    output in_shamt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result
  );

  modport slave (
    input  in_valid,
    input  in_arith,
    input  in_operand,
    input  in_shamt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result
  );

endinterface

// File: rtl/shift_1_right.sv
// Single-bit right step: logical (zero fill) or arithmetic (sign fill).
module shift_1_right
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] in,
  input  logic            arith,
  output logic [XLEN-1:0] out
);

  logic fill;

  assign fill = (arith == SH_ARITH) ? in[XLEN-1] : 1'b0;
  assign out  = {fill, in[XLEN-1:1]};

endmodule

// File: rtl/serial_shift_right.sv
// Multi-cycle SRL/SRA unit: one bit per clock, valid/ready handshake,
// abortable by pipeline flush.
module serial_shift_right
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int SHW  = riscv_pkg::SHW
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  serial_shift_right_if.slave s
);

  shift_state_t    state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            arith_q, arith_d;
  logic [XLEN-1:0] step;

  shift_1_right #(.XLEN(XLEN)) u_step (
    .in    (data_q),
    .arith (arith_q),
    .out   (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    unique case (state_q)
      IDLE: begin
        if (s.in_valid && !flush) begin
          data_d  = s.in_operand;
          cnt_d   = s.in_shamt;
          arith_d = s.in_arith;
          state_d = (s.in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (s.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // flush wins over every transition, including completion
    if (flush) begin
      state_d = IDLE;
    end
  end

  assign s.in_ready   = (state_q == IDLE);
  assign s.out_valid  = (state_q == DONE);
  assign s.out_result = data_q;

endmodule

// File: doc/serial_shift_right.md
# serial_shift_right

Multi-cycle right-shift unit for the execute stage of the pipelined RISC-V core. It implements SRL/SRLI and SRA/SRAI by applying a single-bit right step once per clock under a valid/ready handshake. This gives a small-area alternative to a 32-bit barrel shifter. It is the right-direction counterpart of the core's single-bit left shift, and the pipeline's flush signal can abort it.

## Interface
Parameters:
- XLEN, 32, operand/result width
- SHW, 5, shift-amount width (log2 XLEN)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_arith  in  1  0 = SRL (zero fill), 1 = SRA (sign fill)
- in_operand  in  XLEN  value to shift (rs1)
- in_shamt  in  SHW  shift amount; only the low SHW bits of rs2/imm are used
- flush  in  1  synchronous abort from the pipeline
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  shifted value

## Operation
- States: IDLE, SHIFT, DONE.
- Registers: data_q (XLEN), cnt_q (SHW), arith_q (1).
- IDLE:
  - in_ready = 1.
  - When in_valid && !flush, latch operand, shamt and arith.
  - Next state is DONE if shamt == 0, else SHIFT.
- SHIFT:
  - Each cycle, data_q <= step(data_q) and cnt_q <= cnt_q - 1.
  - When cnt_q == 1, next state is DONE.
- step() is the single-bit shift: {fill, data[XLEN-1:1]}, where fill = arith_q ? data[XLEN-1] : 0. The sign bit is resampled from the current data_q each step, which is equivalent because the fill replicates it.
- DONE:
  - out_valid = 1 and out_result = data_q.
  - out_result is held stable while out_ready = 0.
  - On out_ready, next state is IDLE.
- in_ready = (state == IDLE). Requests never overlap, and a new request cannot be accepted in the same cycle that DONE completes.
- flush has the highest priority. In any state it forces IDLE on the next edge; the in-flight result is discarded and out_valid never rises. A flush in IDLE with in_valid high means the request is not accepted.
- out_result is valid only while out_valid = 1. Outside DONE it shows data_q (don't-care).

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; data_q, cnt_q, arith_q go to 0.
  - Outputs during and after reset: out_valid = 0, out_result = 0, in_ready = 1.
  - Reset mid-operation abandons the request with no output.
- Latency: a request accepted in cycle N gives out_valid = 1 in cycle N + shamt + 1.
  - shamt = 0: cycle N + 1.
  - shamt = 31: cycle N + 32.
- Throughput: one request per shamt + 2 cycles when out_ready is held high.
- out_valid, once asserted, stays high until the cycle out_ready = 1, unless flush or reset intervene.
- in_ready falls in the cycle after acceptance and rises in the cycle after the DONE handshake or a flush.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 32 and SHW = 5.
  - Typedef shift_state_t {IDLE, SHIFT, DONE}.
  - Constants SH_LOGICAL = 1'b0 and SH_ARITH = 1'b1.
- Sub-module shift_1_right: combinational single-bit step with inputs in[XLEN-1:0] and arith, output out[XLEN-1:0]. It is instantiated once on the data_q feedback path.
- Top level holds the FSM, counter and handshake logic only.

## Test plan
- SRL 0x80000000, shamt 4, accepted in cycle N: out_result 0x08000000, out_valid first high in cycle N+5.
- SRA 0x80000000, shamt 4: 0xF8000000 at N+5. SRA 0x80000000, shamt 31: 0xFFFFFFFF at N+32. SRA 0x7FFFFFFF, shamt 31: 0x00000000.
- shamt 0, operand 0x12345678 (either op): 0x12345678 at N+1. in_ready low in N+1 and high the cycle after the handshake.
- Backpressure: SRL 0xF0000000, shamt 8, out_ready low for 3 cycles after out_valid. out_result holds 0x00F00000 and in_ready stays 0 throughout. Handshake on the 4th cycle, then IDLE.
- Flush in the cycle after acceptance of a shamt 10 request: IDLE next cycle, out_valid never asserts. A following request is accepted normally. Flush plus in_valid in IDLE: not accepted.
- rst_n pulsed low asynchronously mid-SHIFT (between clock edges): outputs go to out_valid 0, out_result 0 and in_ready 1 immediately. No stale result appears after release.
